// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared constants and helpers for the ripple-carry adder block.
//
//   ADDER_DEFAULT_N : default operand/result width
//   ADDER_MIN_N     : smallest legal width (overflow needs two carry stages)
//   signed_ovf()    : two's-complement overflow from operand/result sign bits,
//                     an independent formulation used to cross-check the
//                     carry-based overflow in assertions
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int unsigned ADDER_DEFAULT_N = 32;
    localparam int unsigned ADDER_MIN_N     = 2;

    // Overflow iff both operands share a sign and the result's sign differs.
    function automatic logic signed_ovf(
        input logic msb_a,
        input logic msb_b,
        input logic msb_s
    );
        return (msb_a == msb_b) && (msb_s != msb_a);
    endfunction

endpackage

// File: rtl/adder_n_rca_if.sv
// -----------------------------------------------------------------------------
// adder_n_rca_if
//   Bundles the adder's operand and result signals.
//
//   a, b      : N-bit operands            (master -> slave)
//   c_in      : carry into bit 0          (master -> slave)
//   sum       : combinational a+b+c_in    (slave -> master)
//   c_out     : per-stage carry-out       (slave -> master)
//   overflow  : combinational signed ovf  (slave -> master)
//   sum_q     : registered sum            (slave -> master)
//   c_out_q   : registered carry vector   (slave -> master)
//   ovf_q     : registered overflow       (slave -> master)
//
//   master : the party that supplies operands (datapath / testbench)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface adder_n_rca_if
    import adder_pkg::*;
#(
    parameter int unsigned N = ADDER_DEFAULT_N
);

    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic [N-1:0] sum;
    logic [N-1:0] c_out;
    logic         overflow;
    logic [N-1:0] sum_q;
    logic [N-1:0] c_out_q;
    logic         ovf_q;

    modport master (
        output a,
        output b,
        output c_in,
        input  sum,
        input  c_out,
        input  overflow,
        input  sum_q,
        input  c_out_q,
        input  ovf_q
    );

    modport slave (
        input  a,
        input  b,
        input  c_in,
        output sum,
        output c_out,
        output overflow,
        output sum_q,
        output c_out_q,
        output ovf_q
    );

endinterface

// File: rtl/full_adder_1.sv
// -----------------------------------------------------------------------------
// full_adder_1
//   One-bit full adder, the unit cell of the ripple-carry chain.
//
//   i_a, i_b : operand bits
//   i_c_in   : carry in from the previous stage
//   o_s      : sum bit
//   o_c_out  : carry out to the next stage
// -----------------------------------------------------------------------------
module full_adder_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c_in,
    output logic o_s,
    output logic o_c_out
);

    logic w_p;  // propagate

    assign w_p     = i_a ^ i_b;
    assign o_s     = w_p ^ i_c_in;
    assign o_c_out = (i_a & i_b) | (i_c_in & w_p);

endmodule

// File: rtl/adder_n_rca.sv
// -----------------------------------------------------------------------------
// adder_n_rca
//   N-bit ripple-carry adder built from a chain of full_adder_1 cells, with a
//   registered copy of every result for use as an ALU result stage. Unsigned
//   and two's-complement operands share the same datapath.
//
//   clk    : clock; registered outputs update on its rising edge
//   rst_n  : asynchronous active-low reset of the registered outputs
//   bus    : adder_n_rca_if.slave
//              a, b, c_in          operands in
//              sum, c_out, overflow combinational results (zero latency)
//              sum_q, c_out_q, ovf_q registered results (1-cycle latency)
// -----------------------------------------------------------------------------
module adder_n_rca
    import adder_pkg::*;
#(
    parameter int unsigned N = ADDER_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_n_rca_if.slave bus
);

    if (N < ADDER_MIN_N) begin : g_bad_width
        $error("adder_n_rca: N must be at least 2");
    end

    // -------------------------------------------------------------------------
    // Combinational carry chain
    // -------------------------------------------------------------------------
    // w_carry[i] is the carry into stage i; w_carry[i+1] is its carry out.
    logic [N:0]   w_carry;
    logic [N-1:0] w_sum;
    logic         w_ovf;

    assign w_carry[0] = bus.c_in;

    for (genvar gi = 0; gi < N; gi++) begin : g_stage
        full_adder_1 u_fa (
            .i_a     (bus.a[gi]),
            .i_b     (bus.b[gi]),
            .i_c_in  (w_carry[gi]),
            .o_s     (w_sum[gi]),
            .o_c_out (w_carry[gi+1])
        );
    end

    // Carry into the sign bit differs from carry out of it only on overflow.
    assign w_ovf = w_carry[N] ^ w_carry[N-1];

    assign bus.sum      = w_sum;
    assign bus.c_out    = w_carry[N:1];
    assign bus.overflow = w_ovf;

    // -------------------------------------------------------------------------
    // Result register
    // -------------------------------------------------------------------------
    logic [N-1:0] r_sum;
    logic [N-1:0] r_c_out;
    logic         r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_c_out <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_sum   <= w_sum;
            r_c_out <= w_carry[N:1];
            r_ovf   <= w_ovf;
        end
    end

    assign bus.sum_q   = r_sum;
    assign bus.c_out_q = r_c_out;
    assign bus.ovf_q   = r_ovf;

    // -------------------------------------------------------------------------
    // Assertions
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    // Carry-based overflow must agree with the sign-based definition.
    a_ovf_sign: assert property (@(posedge clk)
        w_ovf == signed_ovf(bus.a[N-1], bus.b[N-1], w_sum[N-1]));

    // Registers stay cleared while reset is held.
    a_rst_clear: assert property (@(posedge clk)
        !rst_n |-> (r_sum == '0 && r_c_out == '0 && !r_ovf));

    // Out of reset, each cycle captures the previous cycle's results.
    a_capture: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> (r_sum == $past(w_sum) && r_c_out == $past(w_carry[N:1])
                  && r_ovf == $past(w_ovf)));
`endif

endmodule

// File: tb/tb_adder_n_rca.sv
// -----------------------------------------------------------------------------
// tb_adder_n_rca
//   Self-checking bench for adder_n_rca. Combinational results are compared
//   shortly after operands change; expected registered results go into a
//   scoreboard queue and are popped after the next rising clock edge.
// -----------------------------------------------------------------------------
module tb_adder_n_rca;
    import adder_pkg::*;

    localparam int unsigned N = ADDER_DEFAULT_N;

    typedef struct packed {
        logic [N-1:0] sum;
        logic [N-1:0] c_out;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    adder_n_rca_if #(.N(N)) bus ();

    adder_n_rca #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Arithmetic reference: carry out of stage i is bit i+1 of the sum of
    // the low i+1 bits of each operand plus c_in.
    function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic cin);
        res_t        r;
        logic [63:0] mask;
        logic [63:0] part;
        logic [63:0] full;
        for (int i = 0; i < int'(N); i++) begin
            mask       = (64'd1 << (i + 1)) - 64'd1;
            part       = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
            r.c_out[i] = part[i+1];
        end
        full  = 64'(a) + 64'(b) + 64'(cin);
        r.sum = full[N-1:0];
        r.ovf = (a[N-1] == b[N-1]) && (r.sum[N-1] != a[N-1]);
        return r;
    endfunction

    // Apply operands at the falling edge, check combinational outputs, queue
    // the expected registered result.
    task automatic drive(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input res_t e);
        @(negedge clk);
        bus.a    = a;
        bus.b    = b;
        bus.c_in = cin;
        #1;
        check({tag, ".sum"},      64'(bus.sum),      64'(e.sum));
        check({tag, ".c_out"},    64'(bus.c_out),    64'(e.c_out));
        check({tag, ".overflow"}, 64'(bus.overflow), 64'(e.ovf));
        sb_q.push_back(e);
    endtask

    task automatic capture(input string tag);
        res_t e;
        @(posedge clk);
        #1;
        check({tag, ".sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, ".sum_q"},   64'(bus.sum_q),   64'(e.sum));
            check({tag, ".c_out_q"}, 64'(bus.c_out_q), 64'(e.c_out));
            check({tag, ".ovf_q"},   64'(bus.ovf_q),   64'(e.ovf));
        end
    endtask

    task automatic step(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input res_t e);
        drive(tag, a, b, cin, e);
        capture(tag);
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, ".sum_q"},   64'(bus.sum_q),   64'd0);
        check({tag, ".c_out_q"}, 64'(bus.c_out_q), 64'd0);
        check({tag, ".ovf_q"},   64'(bus.ovf_q),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t e;

        // Reset with nonzero inputs: registers cleared, comb path still live.
        rst_n    = 1'b1;
        bus.a    = 32'd5;
        bus.b    = 32'd7;
        bus.c_in = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_regs_zero("reset");
        check("reset.comb_sum", 64'(bus.sum), 64'd13);
        @(posedge clk);
        #1;
        check_regs_zero("reset_held");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-derived results.
        step("zero_plus", 32'h0000_0000, 32'h7FFF_FFF8, 1'b0,
             '{sum: 32'h7FFF_FFF8, c_out: 32'h0000_0000, ovf: 1'b0});
        step("pos_ovf",   32'h0000_000B, 32'h7FFF_FFFE, 1'b0,
             '{sum: 32'h8000_0009, c_out: 32'h7FFF_FFFE, ovf: 1'b1});
        step("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
             '{sum: 32'h0000_0000, c_out: 32'hFFFF_FFFF, ovf: 1'b0});
        step("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b1,
             '{sum: 32'h0000_0001, c_out: 32'h8000_0000, ovf: 1'b1});
        step("all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
             '{sum: 32'hFFFF_FFFF, c_out: 32'hFFFF_FFFF, ovf: 1'b0});
        step("max_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
             '{sum: 32'h8000_0000, c_out: 32'h7FFF_FFFF, ovf: 1'b1});

        // Sweep across the positive-overflow boundary.
        for (int ia = 0; ia <= 11; ia++) begin
            for (logic [N-1:0] ib = 32'h7FFF_FFF8; ib <= 32'h7FFF_FFFE; ib++) begin
                step("sweep", N'(ia), ib, 1'b0, model(N'(ia), ib, 1'b0));
            end
        end

        // Random operands.
        for (int k = 0; k < 24; k++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic         rc;
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom_range(0, 1));
            step("random", ra, rb, rc, model(ra, rb, rc));
        end

        // Back-to-back operands without a gap: registers follow each cycle.
        drive("pipe0", 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1));
        capture("pipe0");
        drive("pipe1", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, model(32'hDEAD_BEEF, 32'h2152_4111, 1'b0));
        capture("pipe1");

        // Mid-cycle reset discards the captured result immediately.
        #2 rst_n = 1'b0;
        #1;
        check_regs_zero("mid_rst");
        e = model(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
        check("mid_rst.comb_sum", 64'(bus.sum), 64'(e.sum));
        @(posedge clk);
        #1;
        check_regs_zero("mid_rst_held");

        // Release, then the first rising edge captures the live sum.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_regs_zero("post_rst");
        step("post_rst", 32'h0000_1000, 32'hFFFF_F000, 1'b0,
             '{sum: 32'h0000_0000, c_out: 32'hFFFF_F000, ovf: 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
